// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and datapath select codes.
// Pure constants and two small legality helpers; no timing of its own.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    EXEC_JALR = 4'd11,
    JALR_PC   = 4'd12,
    LUI_WB    = 4'd13,
    HALT      = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MDR    = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;
  localparam logic [1:0] RES_IMM    = 2'd3;

  localparam logic [1:0] SRC1_PC    = 2'd0;
  localparam logic [1:0] SRC1_OLDPC = 2'd1;
  localparam logic [1:0] SRC1_A     = 2'd2;

  localparam logic [1:0] SRC2_B     = 2'd0;
  localparam logic [1:0] SRC2_IMM   = 2'd1;
  localparam logic [1:0] SRC2_FOUR  = 2'd2;

  localparam logic [1:0] BR_EQ = 2'd0;
  localparam logic [1:0] BR_NE = 2'd1;
  localparam logic [1:0] BR_LT = 2'd2;
  localparam logic [1:0] BR_GE = 2'd3;

  function automatic logic alu_func3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
           (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic branch_func3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps aluop plus func3/func7[5] to an ALUControl code.
// Purely combinational; zero latency.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       is_rtype,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (func3)
          3'b000:  alu_control = (is_rtype && func7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main Moore FSM for the multicycle RV32I datapath; outputs decode the current state.
// Instruction latency 3-5 cycles from FETCH; HALT on any unsupported encoding until reset.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       branch,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrc1,
  output logic [1:0] ALUSrc2,
  output logic [1:0] sel_branch,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state;
  logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s, branch_s, done_s, illegal_s;
  logic [1:0] aluop;

  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    state_t ns;
    ns = HALT;
    case (op)
      OP_LOAD, OP_STORE: ns = MEM_ADR;
      OP_R:      if (alu_func3_ok(f3) && (f7 == F7_BASE || f7 == F7_ALT)) ns = EXEC_R;
      OP_I:      if (alu_func3_ok(f3)) ns = EXEC_I;
      OP_BRANCH: if (branch_func3_ok(f3)) ns = BRANCH;
      OP_JAL:    ns = JAL;
      OP_JALR:   ns = EXEC_JALR;
      OP_LUI:    ns = LUI_WB;
      default:   ns = HALT;
    endcase
    return ns;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:     state <= DECODE;
        DECODE:    state <= decode_next(opcode, func3, func7);
        MEM_ADR:   state <= (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
        MEM_READ:  state <= MEM_WB;
        MEM_WB:    state <= FETCH;
        MEM_WRITE: state <= FETCH;
        EXEC_R:    state <= ALU_WB;
        EXEC_I:    state <= ALU_WB;
        ALU_WB:    state <= FETCH;
        BRANCH:    state <= FETCH;
        JAL:       state <= ALU_WB;
        EXEC_JALR: state <= JALR_PC;
        JALR_PC:   state <= ALU_WB;
        LUI_WB:    state <= FETCH;
        HALT:      state <= HALT;
        default:   state <= HALT;
      endcase
    end
  end

  always_comb begin
    pc_write_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    branch_s    = 1'b0;
    done_s      = 1'b0;
    illegal_s   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrc1     = SRC1_PC;
    ALUSrc2     = SRC2_B;
    sel_branch  = BR_EQ;
    ImmSrc      = IMM_I;
    aluop       = ALUOP_ADD;
    case (state)
      FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        ALUSrc2    = SRC2_FOUR;
        ResultSrc  = RES_ALURES;
      end
      // Precompute the branch/jump target into ALUOut while the opcode decodes.
      DECODE: begin
        ALUSrc1 = SRC1_OLDPC;
        ALUSrc2 = SRC2_IMM;
        ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      MEM_ADR: begin
        ALUSrc1 = SRC1_A;
        ALUSrc2 = SRC2_IMM;
        ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
      end
      MEM_READ: AdrSrc = 1'b1;
      MEM_WB: begin
        ResultSrc   = RES_MDR;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      MEM_WRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        done_s      = 1'b1;
      end
      EXEC_R: begin
        ALUSrc1 = SRC1_A;
        aluop   = ALUOP_FUNCT;
      end
      EXEC_I: begin
        ALUSrc1 = SRC1_A;
        ALUSrc2 = SRC2_IMM;
        aluop   = ALUOP_FUNCT;
      end
      ALU_WB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      BRANCH: begin
        ALUSrc1  = SRC1_A;
        aluop    = ALUOP_SUB;
        branch_s = 1'b1;
        done_s   = 1'b1;
        case (func3)
          3'b001:  sel_branch = BR_NE;
          3'b100:  sel_branch = BR_LT;
          3'b101:  sel_branch = BR_GE;
          default: sel_branch = BR_EQ;
        endcase
      end
      // JALR_PC reuses the JAL drive: the ALU forms the link value while PC loads ALUOut.
      JAL, JALR_PC: begin
        pc_write_s = 1'b1;
        ALUSrc1    = SRC1_OLDPC;
        ALUSrc2    = SRC2_FOUR;
      end
      EXEC_JALR: begin
        ALUSrc1 = SRC1_A;
        ALUSrc2 = SRC2_IMM;
      end
      LUI_WB: begin
        ImmSrc      = IMM_U;
        ResultSrc   = RES_IMM;
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      HALT:    illegal_s = 1'b1;
      default: illegal_s = 1'b1;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .func3       (func3),
    .func7_5     (func7[5]),
    .is_rtype    (opcode == OP_R),
    .alu_control (ALUControl)
  );

  // Reset must kill every side effect immediately, not at the next edge.
  assign PCWrite    = rst & pc_write_s;
  assign MemWrite   = rst & mem_write_s;
  assign IRWrite    = rst & ir_write_s;
  assign RegWrite   = rst & reg_write_s;
  assign branch     = rst & branch_s;
  assign instr_done = rst & done_s;
  assign illegal    = rst & illegal_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Random-instruction bench: a per-instruction control-sequence model feeds a scoreboard queue,
// and a negedge monitor pops one expected control word per cycle.
module tb_multicycle_controller;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011,
                         T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                         T_JALR = 7'b1100111, T_LUI = 7'b0110111;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw, br;
    logic [1:0] res, s1, s2, selb;
    logic [2:0] alu, imm;
    logic       done, ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, branch, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrc1, ALUSrc2, sel_branch;
  logic [2:0] ALUControl, ImmSrc;

  int checks = 0;
  int errors = 0;
  ctl_t  exp_q[$];
  string lbl_q[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .branch(branch), .ResultSrc(ResultSrc), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .sel_branch(sel_branch), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic ctl_t actual();
    ctl_t c;
    c = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, branch, ResultSrc, ALUSrc1,
          ALUSrc2, sel_branch, ALUControl, ImmSrc, instr_done, illegal};
    return c;
  endfunction

  task automatic check(input ctl_t e, input string nm);
    ctl_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string s;
      e = exp_q.pop_front();
      s = lbl_q.pop_front();
      check(e, s);
    end
  end

  task automatic push(input ctl_t c, input string nm);
    exp_q.push_back(c);
    lbl_q.push_back(nm);
  endtask

  function automatic ctl_t reset_word();
    ctl_t c = '0;
    c.s2 = 2; c.res = 2;
    return c;
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  return sub_ok ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Expected control sequence of one instruction, written from the per-instruction recipe.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input string nm, output int cycles, output bit halted);
    ctl_t c;
    bit   legal;
    int   n0;
    logic [1:0] sel_tab [8];
    sel_tab = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
    n0 = exp_q.size();
    opcode = op; func3 = f3; func7 = f7;
    halted = 1'b0;
    c = '0; c.irw = 1; c.pcw = 1; c.s2 = 2; c.res = 2; push(c, {nm, " fetch"});
    c = '0; c.s1 = 1; c.s2 = 1; c.imm = (op == T_JAL) ? 3'd3 : 3'd2; push(c, {nm, " decode"});
    case (op)
      T_R:  legal = (f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7}) && (f7 == 7'h00 || f7 == 7'h20);
      T_I:  legal = f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
      T_BR: legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
      T_LOAD, T_STORE, T_JAL, T_JALR, T_LUI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c = '0; c.ill = 1;
      repeat (3) push(c, {nm, " halt"});
      halted = 1'b1;
    end else begin
      case (op)
        T_LOAD, T_STORE: begin
          c = '0; c.s1 = 2; c.s2 = 1; c.imm = (op == T_LOAD) ? 3'd0 : 3'd1;
          push(c, {nm, " madr"});
          if (op == T_LOAD) begin
            c = '0; c.adr = 1; push(c, {nm, " mread"});
            c = '0; c.res = 1; c.regw = 1; c.done = 1; push(c, {nm, " mwb"});
          end else begin
            c = '0; c.adr = 1; c.memw = 1; c.done = 1; push(c, {nm, " mwrite"});
          end
        end
        T_R, T_I: begin
          c = '0; c.s1 = 2; c.s2 = (op == T_I) ? 2'd1 : 2'd0;
          c.alu = alu_of(f3, (op == T_R) && f7[5]);
          push(c, {nm, " exec"});
        end
        T_BR: begin
          c = '0; c.s1 = 2; c.alu = 3'b001; c.br = 1; c.done = 1; c.selb = sel_tab[f3];
          push(c, {nm, " branch"});
        end
        T_JALR: begin
          c = '0; c.s1 = 2; c.s2 = 1; push(c, {nm, " exec"});
        end
        T_LUI: begin
          c = '0; c.imm = 4; c.res = 3; c.regw = 1; c.done = 1; push(c, {nm, " lui"});
        end
        default: ;
      endcase
      if (op == T_JAL || op == T_JALR) begin
        c = '0; c.pcw = 1; c.s1 = 1; c.s2 = 2; push(c, {nm, " pcload"});
      end
      if (op inside {T_R, T_I, T_JAL, T_JALR}) begin
        c = '0; c.regw = 1; c.done = 1; push(c, {nm, " wb"});
      end
    end
    cycles = exp_q.size() - n0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    push(reset_word(), "reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input string nm);
    int cycles;
    bit halted;
    issue(op, f3, f7, nm, cycles, halted);
    repeat (cycles) @(posedge clk);
    #1;
    if (halted) pulse_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cycles;
    bit halted;
    logic [6:0] op, f7;
    logic [2:0] f3;
    rst = 1'b0; opcode = '0; func3 = '0; func7 = '0;
    push(reset_word(), "reset idle");
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;

    run(T_R,    3'b000, 7'h00, "add");
    run(T_R,    3'b000, 7'h20, "sub");
    run(T_I,    3'b000, 7'h20, "addi f7alt");
    run(T_LOAD, 3'b010, 7'h00, "lw");
    run(T_STORE,3'b010, 7'h00, "sw");
    run(T_BR,   3'b001, 7'h00, "bne");
    run(T_BR,   3'b100, 7'h00, "blt");
    run(T_BR,   3'b010, 7'h00, "bad branch");
    run(T_JAL,  3'b000, 7'h00, "jal");
    run(T_JALR, 3'b000, 7'h00, "jalr");
    run(T_LUI,  3'b000, 7'h00, "lui");
    run(T_R,    3'b001, 7'h00, "sll unsupported");
    run(T_R,    3'b000, 7'h01, "bad func7");

    // Abort a store while MemWrite is asserted; the enable must fall without a clock edge.
    issue(T_STORE, 3'b010, 7'h00, "sw abort", cycles, halted);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check(reset_word(), "memwrite async drop");
    exp_q.delete();
    lbl_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    run(T_R, 3'b111, 7'h00, "and after abort");

    for (int i = 0; i < 80; i++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom);
      case ($urandom_range(0, 9))
        0, 9: begin
          op = T_R;
          if ($urandom_range(0, 3) != 0) f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        1: op = T_I;
        2: op = T_LOAD;
        3: op = T_STORE;
        4: op = T_BR;
        5: op = T_JAL;
        6: op = T_JALR;
        7: op = T_LUI;
        default: begin
          op = 7'($urandom);
          while (op inside {T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI})
            op = 7'($urandom);
        end
      endcase
      run(op, f3, f7, $sformatf("rnd%0d op%b f3%b f7%h", i, op, f3, f7));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
